// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional watchdog macro consumed by the top level: UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int BYTE_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit strictly after
// the pointer, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int cand;
    o_idx = '0;
    o_any = 1'b0;
    cand  = 0;
    // Offsets 1..NUM_REQ visit every requester once, the pointer itself last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[cand]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add a per-transfer watchdog driving timeout_err.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GW             = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [GW-1:0]             grant_id,
  output logic                      arb_idle,
  output logic                      timeout_err,
  output arb_state_e                dbg_state
);

  // Handshake: a byte is taken from requester i in the single cycle where
  // req_ready[i] is high; req_valid is only looked at while in IDLE.
  arb_state_e          r_state, w_next_state;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant_id;
  logic [BYTE_W-1:0]   r_tx_data;
  logic [GW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic                w_to_hit;
  logic [NUM_REQ-1:0]  w_ready;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(GW)) u_picker (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_timeout_err;

  assign w_to_hit = ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) &&
                    (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_to_hit;
      if (r_state == ST_ISSUE)
        r_to_cnt <= '0;
      else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE))
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_pick_any) w_next_state = ST_ISSUE;
      ST_ISSUE:     w_next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (w_to_hit) w_next_state = ST_IDLE;
                    else if (tx_busy) w_next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (w_to_hit || !tx_busy) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_any) begin
        r_grant_id <= w_pick_idx;
        r_tx_data  <= req_data[w_pick_idx*BYTE_W +: BYTE_W];
      end
      // The pointer only moves once a transfer is finished or abandoned.
      if (((r_state == ST_WAIT_DONE) && !tx_busy) || w_to_hit)
        r_rr_ptr <= r_grant_id;
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == ST_ISSUE) w_ready[r_grant_id] = 1'b1;
  end

  assign req_ready = w_ready;
  assign tx_start  = (r_state == ST_ISSUE);
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign arb_idle  = (r_state == ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order and bytes are pushed to a
// queue as requests are posted and popped on every tx_start.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int W  = GW + 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic           tx_busy;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [GW-1:0]  grant_id;
  logic           arb_idle;
  logic           timeout_err;
  arb_state_e     dbg_state;

  logic [7:0]     dbyte [N];
  logic [W-1:0]   exp_q [$];
  logic [7:0]     cur_data;
  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc = 0;
  int             last_start = -100;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_idle    (arb_idle),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = dbyte[i];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_q.push_back({GW'(id), d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arb_idle"}, arb_idle, 1);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // drivers
  task automatic expect_start(input logic [N-1:0] next_valid);
    int waited = 0;
    logic [W-1:0] e;
    logic [31:0] onehot;
    @(negedge clk);
    while (tx_start !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (tx_start !== 1'b1) begin
      check("start_timeout", tx_start, 1);
      req_valid = next_valid;
      return;
    end
    check("start_spacing", 32'((cyc - last_start) >= 4), 1);
    last_start = cyc;
    if (exp_q.size() == 0) begin
      check("unexpected_start", tx_start, 0);
    end else begin
      e = exp_q.pop_front();
      onehot = 32'd1 << e[W-1:8];
      cur_data = e[7:0];
      check("grant_id", grant_id, e[W-1:8]);
      check("tx_data", tx_data, e[7:0]);
      check("req_ready", req_ready, onehot);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i]) dbyte[i] = dbyte[i] + 8'h10;
    req_valid = next_valid;
  endtask

  task automatic transmit(input int busy_len);
    logic stable = 1'b1;
    tx_busy = 1'b1;
    repeat (busy_len) begin
      @(negedge clk);
      if (tx_data !== cur_data) stable = 1'b0;
    end
    tx_busy = 1'b0;
    check("tx_data_stable", stable, 1);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (arb_idle !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("return_idle", arb_idle, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    tx_busy = 1'b0;
    for (int i = 0; i < N; i++) dbyte[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_state", dbg_state, ST_IDLE);

    // single request, one-cycle latency
    reset = 1'b0;
    dbyte[2] = 8'h55;
    req_valid = 4'b0100;
    @(negedge clk);
    check("lat_req_ready", req_ready, 4'b0100);
    check("lat_tx_start", tx_start, 1);
    check("lat_tx_data", tx_data, 8'h55);
    check("lat_grant_id", grant_id, 2);
    req_valid = '0;
    @(negedge clk);
    check("start_one_cycle", tx_start, 0);
    check("ready_one_cycle", req_ready, 0);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("in_wait_done", dbg_state, ST_WAIT_DONE);

    // reset mid-transfer with every requester pending
    reset = 1'b1;
    tx_busy = 1'b0;
    req_valid = 4'b1111;
    dbyte[0] = 8'hA0; dbyte[1] = 8'hA1; dbyte[2] = 8'hA2; dbyte[3] = 8'hA3;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    last_start = -100;

    // all four held: 0,1,2,3,0 with data advancing after each grant
    push_exp(0, 8'hA0); push_exp(1, 8'hA1); push_exp(2, 8'hA2);
    push_exp(3, 8'hA3); push_exp(0, 8'hB0);
    for (int g = 0; g < 4; g++) begin
      expect_start(4'b1111);
      transmit(20);
    end
    expect_start(4'b1010);
    transmit(20);

    // requesters 1 and 3 alternate
    push_exp(1, 8'hB1); push_exp(3, 8'hB3); push_exp(1, 8'hC1); push_exp(3, 8'hC3);
    for (int g = 0; g < 3; g++) begin
      expect_start(4'b1010);
      transmit(3);
    end
    expect_start(4'b0001);
    transmit(3);

    // single requester granted back-to-back across the wrap
    push_exp(0, 8'hC0); push_exp(0, 8'hD0); push_exp(0, 8'hE0);
    expect_start(4'b0001);
    transmit(3);
    expect_start(4'b0001);
    transmit(3);
    expect_start(4'b0000);

    // transmitter never goes busy
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int k = 0;
      while (timeout_err !== 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("timeout_cycle", k, 17);
      check("timeout_idle", arb_idle, 1);
      @(negedge clk);
      check("timeout_one_cycle", timeout_err, 0);
    end
`else
    repeat (40) @(negedge clk);
    check("stuck_not_idle", arb_idle, 0);
    check("stuck_state", dbg_state, ST_WAIT_BUSY);
    check("stuck_no_timeout", timeout_err, 0);
    transmit(3);
`endif
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, clk cycles allowed per transmission (used only under REQ-024).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ  bit i high = requester i offers a byte.
REQ-006 SHALL have port req_data  in  NUM_REQ*8  byte i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-008 SHALL have port tx_start  out  1  one-cycle start pulse to the shared UART transmitter.
REQ-009 SHALL have port tx_data  out  8  byte for the transmitter, stable from tx_start until return to IDLE.
REQ-010 SHALL have port tx_busy  in  1  transmitter busy flag (high while framing a byte).
REQ-011 SHALL have port grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-012 SHALL have port arb_idle  out  1  high when in IDLE.
REQ-013 SHALL have port timeout_err  out  1  one-cycle error pulse (constant 0 when REQ-025 applies).

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: on an edge with any req_valid high, SHALL select the first set bit searching upward from rr_ptr+1 modulo NUM_REQ, register req_data of the winner into tx_data, set grant_id, pulse req_ready[winner] in the following cycle and enter ISSUE.
REQ-016 ISSUE: SHALL assert tx_start for exactly one cycle (the same cycle as the req_ready pulse), then enter WAIT_BUSY.
REQ-017 WAIT_BUSY: SHALL stay until tx_busy is sampled high, then enter WAIT_DONE.
REQ-018 WAIT_DONE: SHALL stay until tx_busy is sampled low, then set rr_ptr to grant_id and enter IDLE.
REQ-019 req_valid SHALL be ignored outside IDLE; a requester SHALL drop or advance its data in the cycle after its req_ready pulse.
REQ-020 Latency: request sampled at edge T yields req_ready and tx_start high in cycle T+1; minimum spacing between consecutive tx_start pulses SHALL be 4 cycles.
REQ-021 Simultaneous requests SHALL be served round-robin, so no requester waits more than NUM_REQ-1 grants while held valid.
REQ-022 rr_ptr wrap-around SHALL be modulo NUM_REQ; a single active requester SHALL be granted back-to-back.

Reset
REQ-023 While reset is sampled high, state SHALL go to IDLE, rr_ptr to NUM_REQ-1 (requester 0 highest priority), req_ready, tx_start and timeout_err to 0, tx_data and grant_id to 0, and arb_idle to 1; reset mid-transfer SHALL abandon the transfer without a req_ready or tx_start pulse.

Configuration
REQ-024 With UART_ARB_TIMEOUT_EN defined, a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on entry to WAIT_BUSY and count in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT_CYCLES it SHALL pulse timeout_err for one cycle, update rr_ptr to grant_id and return to IDLE.
REQ-025 Without UART_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, and WAIT_BUSY and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-026 Package uart_arb_pkg SHALL hold the state enum typedef, default NUM_REQ and TIMEOUT_CYCLES constants, and the byte-width constant (8).
REQ-027 The round-robin search SHALL be a combinational sub-module rr_picker (inputs: request vector and pointer; outputs: winner index and any-valid flag).

Verification
REQ-028 Reset, then req_valid=4'b0100 with byte 2 = 0x55 -> one cycle later req_ready=4'b0100, tx_start=1, tx_data=0x55, grant_id=2.
REQ-029 All four valid and held, transmitter model busy for 20 cycles per byte -> grants in order 0,1,2,3,0, with tx_start pulses at least 4 cycles apart.
REQ-030 Requesters 1 and 3 held continuously -> grants alternate 1,3,1,3.
REQ-031 Macro defined, TIMEOUT_CYCLES=16, tx_busy stuck low -> timeout_err pulses 16 cycles after entry to WAIT_BUSY, then arb_idle=1; macro undefined -> stays in WAIT_BUSY (arb_idle=0) indefinitely.
REQ-032 reset asserted during WAIT_DONE -> next cycle arb_idle=1 and all outputs at reset values; next grant goes to requester 0 if it is valid.
